// File: rtl/streebog_block_feeder.sv
// Streebog block feeder: packs a 32-bit word stream into 512-bit blocks
// and sequences the core's init/update/final commands.
module streebog_block_feeder #(
  parameter int GUARD_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  input  logic [2:0]   s_bytes,
  input  logic         short_mode,
  output logic [511:0] core_block,
  output logic [9:0]   core_block_length,
  output logic         core_init,
  output logic         core_update,
  output logic         core_final,
  output logic         core_short_mode,
  input  logic         core_ready,
  input  logic [511:0] core_digest,
  input  logic         core_digest_valid,
  output logic [511:0] digest,
  output logic         digest_valid,
  output logic         busy
);
  localparam int GW =
    (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, INIT, FILL, UPD, FIN, WAITD
  } state_t;

  state_t        state, state_n;
  logic [511:0]  blk;
  logic [3:0]    word_cnt;
  logic [9:0]    len;
  logic          fin_pend;
  logic          fresh;
  logic          ready_seen;
  logic          short_q;
  logic [GW-1:0] gcnt;
  logic          accept;
  logic          upd_exit;
  logic          cap;
  logic          guard_done;
  logic [3:0]    slot;
  logic [2:0]    nbytes;
  logic [31:0]   mask;
  logic [31:0]   word;
  logic [9:0]    last_len;

  assign slot = (state == IDLE) ? 4'd0 : word_cnt;
  assign nbytes =
    (s_bytes == 3'd0 || s_bytes > 3'd4) ? 3'd4 : s_bytes;
  // Bytes are MSB-aligned, so the mask keeps the top nbytes bytes.
  assign mask = s_last
    ? ~(32'hFFFF_FFFF >> {nbytes, 3'b000})
    : 32'hFFFF_FFFF;
  assign word = s_data & mask;
  assign last_len =
    {1'b0, slot, 5'd0} + {4'd0, nbytes, 3'd0};
  assign guard_done = !fresh && (gcnt == '0);

  always_comb begin
    state_n     = state;
    s_ready     = 1'b0;
    accept      = 1'b0;
    core_init   = 1'b0;
    core_update = 1'b0;
    core_final  = 1'b0;
    upd_exit    = 1'b0;
    cap         = 1'b0;
    unique case (state)
      IDLE: begin
        s_ready = core_ready && ready_seen;
        accept  = s_valid && s_ready;
        if (accept) state_n = INIT;
      end
      INIT: begin
        core_init = fresh;
        if (guard_done && core_ready)
          state_n = fin_pend ? FIN : FILL;
      end
      FILL: begin
        s_ready = 1'b1;
        accept  = s_valid;
        if (s_valid) begin
          if (s_last)
            state_n = (last_len == 10'd512) ? UPD : FIN;
          else if (word_cnt == 4'd15)
            state_n = UPD;
        end
      end
      UPD: begin
        core_update = fresh;
        if (guard_done && core_ready) begin
          upd_exit = 1'b1;
          state_n  = fin_pend ? FIN : FILL;
        end
      end
      FIN: begin
        core_final = fresh;
        if (guard_done) state_n = WAITD;
      end
      WAITD: begin
        if (core_digest_valid && core_ready) begin
          cap     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    core_block_length = 10'd0;
    unique case (1'b1)
      state == UPD:   core_block_length = 10'd512;
      state == FIN:   core_block_length = len;
      state == WAITD: core_block_length = len;
      default:        core_block_length = 10'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fresh <= 1'b0;
    end else begin
      state <= state_n;
      fresh <= (state_n != state);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk          <= '0;
      word_cnt     <= '0;
      len          <= '0;
      fin_pend     <= 1'b0;
      ready_seen   <= 1'b0;
      short_q      <= 1'b0;
      gcnt         <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
    end else begin
      ready_seen <= ready_seen | core_ready;
      if (fresh)
        gcnt <= GW'(GUARD_CYCLES);
      else if (gcnt != '0)
        gcnt <= gcnt - GW'(1);
      if (accept) begin
        word_cnt <= slot + 4'd1;
        if (state == IDLE) begin
          blk          <= {word, 480'd0};
          short_q      <= short_mode;
          digest_valid <= 1'b0;
          fin_pend     <= 1'b0;
        end else begin
          blk[{~slot, 5'd0} +: 32] <= word;
        end
        // A full final block still needs a trailing empty final.
        if (s_last) begin
          len <= (last_len == 10'd512)
            ? 10'd0 : last_len;
          fin_pend <= (state == IDLE)
            || (last_len == 10'd512);
        end
      end
      if (upd_exit) begin
        blk      <= '0;
        word_cnt <= '0;
      end
      if (state == FIN) fin_pend <= 1'b0;
      if (cap) begin
        digest       <= core_digest;
        digest_valid <= 1'b1;
      end
    end
  end

  assign core_block      = blk;
  assign core_short_mode = short_q;
  assign busy            = (state != IDLE);

endmodule
